// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobing scanner for a 4x4 active-low matrix keypad.
// Drives one column low at a time and samples the synchronized rows once per
// dwell period. A single-key press must be seen DEBOUNCE_CNT consecutive
// samples to be accepted, and a release must likewise persist. Ghosted
// multi-key samples are ignored.
//
// Ports:
//   clk       - block clock, all state on rising edge
//   rst_n     - synchronous active-low reset
//   row       - keypad rows, active-low, asynchronous to clk
//   col       - column drive, active-low one-hot (registered)
//   key_code  - last accepted key, row_idx*4 + col_idx
//   key_valid - one-cycle pulse on press acceptance
//   key_held  - high from press acceptance until release acceptance
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned MW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD
  } state_e;

  state_e          state_q,    state_d;
  logic [DW-1:0]   dwell_q,    dwell_d;
  logic [1:0]      col_idx_q,  col_idx_d;
  logic [3:0]      col_q,      col_d;
  logic [MW-1:0]   match_q,    match_d;
  logic [1:0]      cand_row_q, cand_row_d;
  logic [1:0]      cand_col_q, cand_col_d;
  logic [3:0]      code_q,     code_d;
  logic            valid_q,    valid_d;
  logic            held_q,     held_d;
  logic [3:0]      sync1_q;
  logic [3:0]      rs_q;

  logic            tick;
  logic [2:0]      zero_cnt;
  logic [1:0]      zero_idx;
  logic [3:0]      cand_pat;
  logic [MW-1:0]   match_inc;

  assign tick      = (dwell_q == DWELL_LAST);
  assign cand_pat  = ~(4'b0001 << cand_row_q);
  assign match_inc = match_q + 1'b1;

  // Count low rows and remember the index of the (only meaningful) low row.
  always_comb begin
    zero_cnt = '0;
    zero_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rs_q[i]) begin
        zero_cnt = zero_cnt + 3'd1;
        zero_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = tick ? '0 : dwell_q + 1'b1;
    col_idx_d  = col_idx_q;
    match_d    = match_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;

    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (zero_cnt == 3'd1) begin
            cand_row_d = zero_idx;
            cand_col_d = col_idx_q;
            if (DEBOUNCE_CNT == 1) begin
              code_d  = {zero_idx, col_idx_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              match_d = '0;
              state_d = ST_HOLD;
            end else begin
              match_d = MW'(1);
              state_d = ST_DEBOUNCE;
            end
          end else begin
            // Idle or ghosted sample: keep scanning.
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q == cand_pat) begin
            if (match_inc == MATCH_LAST) begin
              code_d  = {cand_row_q, cand_col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              match_d = '0;
              state_d = ST_HOLD;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_HOLD: begin
          // match_q is reused as the release counter while holding.
          if (rs_q == 4'b1111) begin
            if (match_inc == MATCH_LAST) begin
              held_d    = 1'b0;
              match_d   = '0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = ST_SCAN;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        default: begin
          match_d = '0;
          state_d = ST_SCAN;
        end
      endcase
    end

    col_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SCAN;
      dwell_q    <= '0;
      col_idx_q  <= '0;
      col_q      <= 4'b1110;
      match_q    <= '0;
      cand_row_q <= '0;
      cand_col_q <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      sync1_q    <= '1;
      rs_q       <= '1;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      match_q    <= match_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      sync1_q    <= row;
      rs_q       <= sync1_q;
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A behavioural keypad pulls row r low while a pressed key (r,c) has its
// column c driven low. Cycle k is the k-th rising edge after reset release.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int nvec = 0;
  int nerr = 0;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
  end

  typedef struct {
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  col;
    logic        valid;
    logic        held;
    logic [3:0]  code;
  } vec_t;

  localparam int NTBL = 82;
  vec_t tbl [0:NTBL-1];

  logic [3:0] lcol  [0:127];
  logic [3:0] lcode [0:127];
  logic       lv    [0:127];
  logic       lh    [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input int k);
    @(posedge clk);
    #1;
    lcol[k]  = col;
    lcode[k] = key_code;
    lv[k]    = key_valid;
    lh[k]    = key_held;
  endtask

  function automatic int count_valid(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (lv[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    logic [3:0] one;
    one = 4'b0001;

    // Scenario 1 (idle) and 4 (ghost pair in column 1) as per-cycle vectors.
    for (int s = 0; s < 2; s++) begin
      tbl[s*41] = '{rst_n: 1'b0, keys: (s == 0) ? 16'h0000 : 16'h0202,
                    col: 4'b1110, valid: 1'b0, held: 1'b0, code: 4'h0};
      for (int k = 0; k < 40; k++)
        tbl[s*41+1+k] = '{rst_n: 1'b1, keys: (s == 0) ? 16'h0000 : 16'h0202,
                          col: ~(one << (((k + 1) / 4) % 4)),
                          valid: 1'b0, held: 1'b0, code: 4'h0};
    end

    for (int i = 0; i < NTBL; i++) begin
      rst_n = tbl[i].rst_n;
      keys  = tbl[i].keys;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_col", i),   32'(col),       32'(tbl[i].col));
      check($sformatf("tbl%0d_valid", i), 32'(key_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_held", i),  32'(key_held),  32'(tbl[i].held));
      check($sformatf("tbl%0d_code", i),  32'(key_code),  32'(tbl[i].code));
    end
    rst_n = 1'b1;

    // Scenario 2: key (1,2) held, released after cycle 59.
    keys = 16'h0040;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      step(k);
      if (k == 59) keys = '0;
    end
    check("s2_valid_count", count_valid(0, 99), 1);
    check("s2_valid_pre",   32'(lv[18]), 0);
    check("s2_valid_at",    32'(lv[19]), 1);
    check("s2_valid_post",  32'(lv[20]), 0);
    check("s2_code",        32'(lcode[19]), 6);
    check("s2_held_pre",    32'(lh[18]), 0);
    check("s2_held",        32'(lh[19]), 1);
    check("s2_col_frozen",  32'(lcol[11]), 32'(4'b1011));
    check("s2_col_hold",    32'(lcol[40]), 32'(4'b1011));
    check("s2_held_last",   32'(lh[70]), 1);
    check("s2_held_fall",   32'(lh[71]), 0);
    check("s2_col_resume",  32'(lcol[71]), 32'(4'b0111));
    check("s2_col_dwell",   32'(lcol[74]), 32'(4'b0111));
    check("s2_col_next",    32'(lcol[75]), 32'(4'b1110));
    check("s2_code_kept",   32'(lcode[99]), 6);

    // Scenario 3: key (3,0) bounces low/high, then stays low from cycle 7.
    keys = 16'h1000;
    do_reset();
    for (int k = 0; k < 51; k++) begin
      step(k);
      if (k == 1) keys = '0;
      if (k == 7) keys = 16'h1000;
    end
    check("s3_col_frozen",  32'(lcol[3]), 32'(4'b1110));
    check("s3_col_abort",   32'(lcol[7]), 32'(4'b1101));
    check("s3_no_early",    count_valid(0, 30), 0);
    check("s3_valid_count", count_valid(0, 50), 1);
    check("s3_valid_at",    32'(lv[31]), 1);
    check("s3_code",        32'(lcode[31]), 12);
    check("s3_held_pre",    32'(lh[30]), 0);

    // Scenario 5: key (2,3) accepted, reset pulse mid-hold, re-accepted.
    keys = 16'h0800;
    do_reset();
    for (int k = 0; k < 30; k++) step(k);
    check("s5_valid_at",    32'(lv[23]), 1);
    check("s5_code",        32'(lcode[23]), 11);
    check("s5_valid_count", count_valid(0, 29), 1);
    check("s5_held",        32'(lh[29]), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("s5_rst_held",  32'(key_held), 0);
    check("s5_rst_code",  32'(key_code), 0);
    check("s5_rst_col",   32'(col), 32'(4'b1110));
    check("s5_rst_valid", 32'(key_valid), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 41; k++) step(k);
    check("s5_re_count",    count_valid(0, 40), 1);
    check("s5_re_valid_at", 32'(lv[23]), 1);
    check("s5_re_code",     32'(lcode[23]), 11);

    // Scenario 6: key (2,1) in hold: released 2 ticks, pressed 1, released 3.
    keys = 16'h0200;
    do_reset();
    for (int k = 0; k < 61; k++) begin
      step(k);
      if (k == 20) keys = '0;
      if (k == 28) keys = 16'h0200;
      if (k == 32) keys = '0;
    end
    check("s6_valid_at",    32'(lv[15]), 1);
    check("s6_code",        32'(lcode[15]), 9);
    check("s6_held_glitch", 32'(lh[35]), 1);
    check("s6_held_last",   32'(lh[42]), 1);
    check("s6_held_fall",   32'(lh[43]), 0);
    check("s6_col_resume",  32'(lcol[43]), 32'(4'b1011));
    check("s6_valid_count", count_valid(0, 60), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
